// File: rtl/txn_seq_gen.sv
// ---------------------------------------------------------------------------
// txn_seq_gen
//   Stimulus generator for an a / b / stop handshake. A sampled rising edge
//   on start launches one transaction: a b beat on the next cycle, then GAP
//   cycles later a single cycle with a and stop asserted together. With
//   GAP=2 the traffic satisfies
//      $rose(start) |=> (##[1:2] a) intersect (b ##[2:3] stop)
//   and any other GAP produces negative stimulus for that property.
//
// Parameters
//   GAP     cycles from the b beat to the a/stop beat (1..7)
//   CNT_W   width of txn_cnt / ovr_cnt
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   transaction request, rising edge launches a transaction
//   abort    in   synchronous abort back to IDLE
//   a        out  completion beat (coincident with stop)
//   b        out  first beat of the transaction
//   stop     out  end-of-transaction beat
//   busy     out  high whenever the FSM is not IDLE
//   txn_cnt  out  completed transactions, wraps
//   ovr_cnt  out  rises dropped while busy, saturates at all-ones
// ---------------------------------------------------------------------------
module txn_seq_gen #(
   parameter int GAP   = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             a,
   output logic             b,
   output logic             stop,
   output logic             busy,
   output logic [CNT_W-1:0] txn_cnt,
   output logic [CNT_W-1:0] ovr_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BEAT = 2'd1,
      ST_WAIT = 2'd2,
      ST_FIRE = 2'd3
   } state_t;

   // BEAT already accounts for one cycle and the final WAIT cycle exits on
   // a zero count, hence the GAP-2 preload.
   localparam logic [2:0]       WAIT_LOAD = (GAP >= 2) ? 3'(GAP - 2) : 3'd0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   generate
      if (GAP < 1 || GAP > 7) begin : g_gap_check
         $error("txn_seq_gen: GAP=%0d is outside the legal range 1..7", GAP);
      end
   endgenerate

   state_t           r_state;
   state_t           w_next_state;
   logic             r_start_q;
   logic [2:0]       r_wait_cnt;
   logic [2:0]       w_next_wait;
   logic             w_rise;
   logic             w_txn_inc;
   logic             w_ovr_inc;
   logic             r_a;
   logic             r_b;
   logic             r_stop;
   logic             r_busy;
   logic [CNT_W-1:0] r_txn_cnt;
   logic [CNT_W-1:0] r_ovr_cnt;

   // Same-edge equivalent of $rose(start) as seen by the checker.
   assign w_rise    = start & ~r_start_q;
   // A rise while busy (FIRE included) is dropped and counted, abort or not.
   assign w_ovr_inc = w_rise & (r_state != ST_IDLE);

   // Next-state, wait-counter and completion decode.
   always_comb begin
      w_next_state = r_state;
      w_next_wait  = r_wait_cnt;
      w_txn_inc    = 1'b0;
      if (abort) begin
         // Abort wins over everything, including a rise in IDLE and the
         // completion in FIRE (which therefore is not counted).
         w_next_state = ST_IDLE;
         w_next_wait  = 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  w_next_state = ST_BEAT;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
            ST_BEAT: begin
               if (GAP == 1) begin
                  w_next_state = ST_FIRE;
                  w_next_wait  = 3'd0;
               end else begin
                  w_next_state = ST_WAIT;
                  w_next_wait  = WAIT_LOAD;
               end
            end
            ST_WAIT: begin
               if (r_wait_cnt == 3'd0) begin
                  w_next_state = ST_FIRE;
               end else begin
                  w_next_state = ST_WAIT;
                  w_next_wait  = r_wait_cnt - 3'd1;
               end
            end
            ST_FIRE: begin
               w_next_state = ST_IDLE;
               w_txn_inc    = 1'b1;
            end
            default: begin
               w_next_state = ST_IDLE;
               w_next_wait  = 3'd0;
            end
         endcase
      end
   end

   // State register, start history and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_start_q  <= 1'b0;
         r_wait_cnt <= 3'd0;
      end else begin
         r_state    <= w_next_state;
         r_start_q  <= start;
         r_wait_cnt <= w_next_wait;
      end
   end

   // Outputs registered from the next state: identical timing to decoding
   // r_state, with no combinational path from the inputs to the pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= 1'b0;
         r_b    <= 1'b0;
         r_stop <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_a    <= (w_next_state == ST_FIRE);
         r_b    <= (w_next_state == ST_BEAT);
         r_stop <= (w_next_state == ST_FIRE);
         r_busy <= (w_next_state != ST_IDLE);
      end
   end

   // Completed-transaction (wrapping) and overrun (saturating) counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txn_cnt <= {CNT_W{1'b0}};
         r_ovr_cnt <= {CNT_W{1'b0}};
      end else begin
         if (w_txn_inc) begin
            r_txn_cnt <= r_txn_cnt + CNT_ONE;
         end
         if (w_ovr_inc && (r_ovr_cnt != CNT_MAX)) begin
            r_ovr_cnt <= r_ovr_cnt + CNT_ONE;
         end
      end
   end

   assign a       = r_a;
   assign b       = r_b;
   assign stop    = r_stop;
   assign busy    = r_busy;
   assign txn_cnt = r_txn_cnt;
   assign ovr_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_txn_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_txn_seq_gen
//   Scoreboard bench for txn_seq_gen. Four instances share clock and reset:
//     inst 0: GAP=2, CNT_W=8   basic, overrun, abort, reset cases
//     inst 1: GAP=1            early a/stop (intersect does not hold)
//     inst 2: GAP=3            late a/stop, overrun in FIRE
//     inst 3: GAP=2, CNT_W=2   counter wrap and saturation
//   Edge numbers are relative to a per-scenario base; an output seen just
//   after edge k is what a checker samples at edge k+1, so events are logged
//   as k+1. The directed stimulus pushes the expected b / fire beats, and a
//   monitor pops and compares every beat the DUTs present.
// ---------------------------------------------------------------------------
module tb_txn_seq_gen;

   typedef struct {
      int inst;
      int edge_n;
      int kind;   // 0 = b beat, 1 = a+stop beat, 2 = a/stop disagree
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] st;
   logic [3:0] ab;
   logic [3:0] a_w;
   logic [3:0] b_w;
   logic [3:0] stop_w;
   logic [3:0] busy_w;
   logic [7:0] txn0, ovr0, txn1, ovr1, txn2, ovr2;
   logic [1:0] txn3, ovr3;

   int  cyc    = 0;
   int  base   = 0;
   int  n_cmp  = 0;
   int  n_bad  = 0;
   int  last_b    [4] = '{0, 0, 0, 0};
   int  last_fire [4] = '{0, 0, 0, 0};
   ev_t exp_q[$];

   txn_seq_gen #(.GAP(2), .CNT_W(8)) u_g2 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
      .a(a_w[0]), .b(b_w[0]), .stop(stop_w[0]), .busy(busy_w[0]),
      .txn_cnt(txn0), .ovr_cnt(ovr0));

   txn_seq_gen #(.GAP(1), .CNT_W(8)) u_g1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
      .a(a_w[1]), .b(b_w[1]), .stop(stop_w[1]), .busy(busy_w[1]),
      .txn_cnt(txn1), .ovr_cnt(ovr1));

   txn_seq_gen #(.GAP(3), .CNT_W(8)) u_g3 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(ab[2]),
      .a(a_w[2]), .b(b_w[2]), .stop(stop_w[2]), .busy(busy_w[2]),
      .txn_cnt(txn2), .ovr_cnt(ovr2));

   txn_seq_gen #(.GAP(2), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .abort(ab[3]),
      .a(a_w[3]), .b(b_w[3]), .stop(stop_w[3]), .busy(busy_w[3]),
      .txn_cnt(txn3), .ovr_cnt(ovr3));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int inst, input int e, input int k);
      ev_t ev;
      ev.inst   = inst;
      ev.edge_n = e;
      ev.kind   = k;
      exp_q.push_back(ev);
   endtask

   task automatic step_to(input int n);
      while (cyc < base + n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, expv, cyc);
      end
   endtask

   // Does $rose(start)@rise |=> (##[1:2] a) intersect (b ##[2:3] stop) hold,
   // given where the single b beat and the single a+stop beat landed?
   function automatic int prop_holds(input int rise, input int be, input int fe);
      return ((be == rise + 1) && (fe >= rise + 2) && (fe <= rise + 3) &&
              (fe >= be + 2) && (fe <= be + 3)) ? 1 : 0;
   endfunction

   // Monitor: every beat any instance presents is checked against the queue.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (b_w[i] || a_w[i] || stop_w[i]) begin
               int  kind;
               ev_t e;
               kind = b_w[i] ? 0 : ((a_w[i] && stop_w[i]) ? 1 : 2);
               if (kind == 0) last_b[i] = cyc + 1;
               else           last_fire[i] = cyc + 1;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL beat: inst %0d edge %0d kind %0d, expected no beat",
                           i, cyc + 1, kind);
               end else begin
                  e = exp_q.pop_front();
                  if (e.inst != i || e.edge_n != cyc + 1 || e.kind != kind) begin
                     n_bad++;
                     $display("FAIL beat: inst %0d edge %0d kind %0d, expected inst %0d edge %0d kind %0d",
                              i, cyc + 1, kind, e.inst, e.edge_n, e.kind);
                  end
               end
            end
         end
      end
   end

   initial begin
      int txn_seq [5] = '{1, 2, 3, 0, 1};
      int ovr_seq [4] = '{1, 2, 3, 3};
      rst_n = 1'b0;
      st    = 4'b0000;
      ab    = 4'b0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base  = cyc;

      // ---- reset state --------------------------------------------------
      chk("rst_outs", int'({a_w, b_w, stop_w, busy_w}), 0);
      chk("rst_txn0", int'(txn0), 0);
      chk("rst_ovr0", int'(ovr0), 0);
      chk("rst_cnt3", int'({txn3, ovr3}), 0);

      // ---- basic GAP=2 plus overrun in WAIT -----------------------------
      step_to(2);  st[0] = 1'b1; push(0, base + 4, 0); push(0, base + 6, 1);
      step_to(3);  chk("basic_busy", int'(busy_w[0]), 1); st[0] = 1'b0;
      step_to(4);  st[0] = 1'b1;                // rise at edge 5, state WAIT
      step_to(5);  chk("ovr_cnt1", int'(ovr0), 1);
                   chk("ovr_txn0", int'(txn0), 0);
                   chk("ovr_busy", int'(busy_w[0]), 1);
      step_to(6);  chk("basic_idle", int'(busy_w[0]), 0);
                   chk("basic_txn1", int'(txn0), 1);
                   chk("prop_gap2", prop_holds(base + 3, last_b[0], last_fire[0]), 1);
                   st[0] = 1'b0;
      step_to(7);  st[0] = 1'b1; push(0, base + 9, 0); push(0, base + 11, 1);
      step_to(8);  st[0] = 1'b0;
      step_to(11); chk("second_txn", int'(txn0), 2);
                   chk("second_ovr", int'(ovr0), 1);
                   chk("second_idle", int'(busy_w[0]), 0);

      // ---- abort in WAIT, abort with rise in IDLE, abort out of FIRE ----
      step_to(14); base = cyc;
      step_to(2);  st[0] = 1'b1; push(0, base + 4, 0);
      step_to(4);  ab[0] = 1'b1;
      step_to(5);  ab[0] = 1'b0;
                   chk("abort_outs", int'({a_w[0], b_w[0], stop_w[0], busy_w[0]}), 0);
      step_to(9);  chk("abort_txn", int'(txn0), 2); st[0] = 1'b0;
      step_to(11); st[0] = 1'b1; ab[0] = 1'b1;   // rise and abort together
      step_to(12); ab[0] = 1'b0;
                   chk("abrise_busy", int'(busy_w[0]), 0);
                   chk("abrise_ovr", int'(ovr0), 1);
      step_to(16); chk("abrise_idle", int'(busy_w[0]), 0); st[0] = 1'b0;
      step_to(17); st[0] = 1'b1; push(0, base + 19, 0); push(0, base + 21, 1);
      step_to(18); st[0] = 1'b0;
      step_to(20); ab[0] = 1'b1;                 // abort at edge 21, state FIRE
      step_to(21); ab[0] = 1'b0;
                   chk("abfire_txn", int'(txn0), 2);
                   chk("abfire_busy", int'(busy_w[0]), 0);

      // ---- reset mid-transaction, then reset released with start high ---
      step_to(24); base = cyc;
      step_to(2);  st[0] = 1'b1; push(0, base + 4, 0);
      step_to(4);  st[0] = 1'b0; rst_n = 1'b0;
      #1;
      chk("rstmid_outs", int'({a_w[0], b_w[0], stop_w[0], busy_w[0]}), 0);
      chk("rstmid_cnts", int'({txn0, ovr0}), 0);
      #1;
      rst_n = 1'b1;
      step_to(10); chk("rstmid_txn", int'(txn0), 0);
                   chk("rstmid_busy", int'(busy_w[0]), 0);
                   st[0] = 1'b1; push(0, base + 12, 0); push(0, base + 14, 1);
                   rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step_to(14); chk("rsthi_txn", int'(txn0), 1); st[0] = 1'b0;

      // ---- negative GAP values ------------------------------------------
      step_to(18); base = cyc;
      step_to(2);  st[1] = 1'b1; push(1, base + 4, 0); push(1, base + 5, 1);
      step_to(6);  st[1] = 1'b0;
                   chk("gap1_txn", int'(txn1), 1);
                   chk("prop_gap1", prop_holds(base + 3, last_b[1], last_fire[1]), 0);
      step_to(8);  st[2] = 1'b1; push(2, base + 10, 0); push(2, base + 13, 1);
      step_to(9);  st[2] = 1'b0;
      step_to(12); st[2] = 1'b1;                 // rise at edge 13, state FIRE
      step_to(13); chk("gap3_fire_ovr", int'(ovr2), 1);
                   chk("gap3_txn", int'(txn2), 1);
                   st[2] = 1'b0;
      step_to(14); chk("prop_gap3", prop_holds(base + 9, last_b[2], last_fire[2]), 0);
                   chk("gap3_idle", int'(busy_w[2]), 0);

      // ---- CNT_W=2: wrap of txn_cnt, saturation of ovr_cnt --------------
      step_to(18); base = cyc;
      for (int k = 0; k < 5; k++) begin
         int r;
         r = 3 + 4 * k;
         step_to(r - 1); st[3] = 1'b1; push(3, base + r + 1, 0); push(3, base + r + 3, 1);
         step_to(r);     st[3] = 1'b0;
         step_to(r + 3); chk($sformatf("wrap_txn%0d", k), int'(txn3), txn_seq[k]);
      end
      for (int j = 0; j < 8; j++) begin
         int r;
         r = 27 + 2 * j;
         step_to(r - 1);
         st[3] = 1'b1;
         if ((j % 2) == 0) begin
            push(3, base + r + 1, 0);
            push(3, base + r + 3, 1);
         end
         step_to(r);
         st[3] = 1'b0;
         if ((j % 2) == 1) chk($sformatf("sat_ovr%0d", j / 2), int'(ovr3), ovr_seq[j / 2]);
      end
      step_to(45); chk("wrap_txn_final", int'(txn3), 1);

      step_to(50); chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
